// File: rtl/ct_f_spsram_req_ctrl.sv
// Request front-end for one single-port SRAM macro: optional post-reset zero-fill,
// valid/ready request stream to SRAM cycles, in-order credit-protected read responses.
module ct_f_spsram_req_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 128,
    parameter int RSP_DEPTH  = 3,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q,
    output logic                  dbg_state
);

    // Handshakes: a request transfers on a cycle with req_vld && req_rdy, a response on a
    // cycle with rsp_vld && rsp_rdy; each producer holds its payload stable until it transfers.

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(RSP_DEPTH);

    typedef enum logic { ST_INIT = 1'b0, ST_RUN = 1'b1 } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  inflight_q, inflight_d;

    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

    logic [CNT_W:0]        used_credits;
    logic                  credit_ok;
    logic                  push;
    logic                  pop;

    // Read credit counts only registered state, so rsp_rdy never reaches req_rdy.
    assign used_credits = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok    = used_credits < CREDITS;

    assign push      = inflight_q;
    assign rsp_vld   = (fifo_cnt_q != '0) && !RST;
    assign pop       = rsp_vld && rsp_rdy;
    assign rsp_data  = fifo_q[rd_ptr_q];
    assign dbg_state = (state_q == ST_RUN);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        a_d        = a_q;
        d_d        = d_q;
        inflight_d = 1'b0;
        req_rdy    = 1'b0;
        init_done  = 1'b0;
        CEN        = 1'b1;
        GWEN       = 1'b1;
        WEN        = '1;
        A          = a_q;
        D          = d_q;
        if (RST) begin
            A = '0;
            D = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    CEN        = 1'b0;
                    GWEN       = 1'b0;
                    WEN        = '0;
                    A          = init_cnt_q;
                    D          = '0;
                    a_d        = init_cnt_q;
                    d_d        = '0;
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                    if (init_cnt_q == '1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    req_rdy   = req_wr || credit_ok;
                    if (req_vld && (req_wr || credit_ok)) begin
                        CEN = 1'b0;
                        A   = req_addr;
                        a_d = req_addr;
                        if (req_wr) begin
                            GWEN = 1'b0;
                            WEN  = ~req_wmask;
                            D    = req_wdata;
                            d_d  = req_wdata;
                        end else begin
                            inflight_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt_q <= '0;
            a_q        <= '0;
            d_q        <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            a_q        <= a_d;
            d_q        <= d_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Q is valid the cycle after the read edge, which is exactly when inflight is set.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= Q;
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_req_ctrl.sv
// Bench for ct_f_spsram_req_ctrl with a 16-word SRAM: directed traffic, a transaction-level
// reference model compared on every cycle, and literal expectations for key points.
module tb_ct_f_spsram_req_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int CRED  = 3;

    localparam logic [DW-1:0] ALL1    = '1;
    localparam logic [DW-1:0] PAT_A5  = {16{8'hA5}};
    localparam logic [DW-1:0] MASK_LO = {8'h00, {120{1'b1}}};
    localparam logic [DW-1:0] EXP7    = {8'hFF, 120'h0};
    localparam logic [DW-1:0] PAT_11  = {16{8'h11}};
    localparam logic [DW-1:0] PAT_22  = {16{8'h22}};
    localparam logic [DW-1:0] PAT_33  = {16{8'h33}};

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld, req_rdy, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, req_wmask;
    logic          rsp_vld, rsp_rdy;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic [AW-1:0] a;
    logic          cen, gwen;
    logic [DW-1:0] wen, d, sram_q;
    logic          dbg_state;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    ct_f_spsram_req_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(CRED), .INIT_EN(1'b1)
    ) dut (
        .CLK(clk), .RST(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .init_done(init_done),
        .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d), .Q(sram_q),
        .dbg_state(dbg_state)
    );

    // ---------------- SRAM macro model (environment) ----------------
    logic [DW-1:0] sram_mem [DEPTH];
    logic          env_seeded = 1'b0;

    always @(posedge clk) begin
        if (!env_seeded) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= {$urandom(), $urandom(), $urandom(), $urandom()};
            env_seeded <= 1'b1;
        end else if (!cen) begin
            if (!gwen) sram_mem[a] <= (sram_mem[a] & wen) | (d & ~wen);
            else       sram_q <= sram_mem[a];
        end
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int            cyc = 0;
    int            m_phase = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            due_q [$];
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    bit            exp_rdy, exp_vld, acc;

    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_req_rdy", req_rdy, 1'b0);
            chk1("rst_rsp_vld", rsp_vld, 1'b0);
            chk1("rst_init_done", init_done, 1'b0);
            chk1("rst_cen", cen, 1'b1);
            chk1("rst_gwen", gwen, 1'b1);
            chk("rst_wen", wen, ALL1);
            chka("rst_a", a, '0);
            chk("rst_d", d, '0);
            m_phase = 0;
            exp_q.delete();
            due_q.delete();
            last_a = '0;
            last_d = '0;
        end else if (m_phase < DEPTH) begin
            chk1("init_cen", cen, 1'b0);
            chk1("init_gwen", gwen, 1'b0);
            chk("init_wen", wen, '0);
            chk("init_d", d, '0);
            chka("init_a", a, AW'(m_phase));
            chk1("init_req_rdy", req_rdy, 1'b0);
            chk1("init_rsp_vld", rsp_vld, 1'b0);
            chk1("init_done_low", init_done, 1'b0);
            last_a = AW'(m_phase);
            last_d = '0;
            m_phase++;
            if (m_phase == DEPTH) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end
        end else begin
            exp_rdy = req_wr || (exp_q.size() < CRED);
            exp_vld = (exp_q.size() > 0) && (due_q[0] <= cyc);
            chk1("run_init_done", init_done, 1'b1);
            chk1("run_req_rdy", req_rdy, exp_rdy);
            chk1("run_rsp_vld", rsp_vld, exp_vld);
            if (exp_vld) chk("run_rsp_data", rsp_data, exp_q[0]);
            acc = req_vld && exp_rdy;
            if (acc && req_wr) begin
                chk1("wr_cen", cen, 1'b0);
                chk1("wr_gwen", gwen, 1'b0);
                chka("wr_a", a, req_addr);
                chk("wr_d", d, req_wdata);
                chk("wr_wen", wen, ~req_wmask);
                ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                last_a = req_addr;
                last_d = req_wdata;
            end else if (acc) begin
                chk1("rd_cen", cen, 1'b0);
                chk1("rd_gwen", gwen, 1'b1);
                chka("rd_a", a, req_addr);
                chk("rd_wen", wen, ALL1);
                chk("rd_d", d, last_d);
                last_a = req_addr;
            end else begin
                chk1("idle_cen", cen, 1'b1);
                chk1("idle_gwen", gwen, 1'b1);
                chk("idle_wen", wen, ALL1);
                chka("idle_a", a, last_a);
                chk("idle_d", d, last_d);
            end
            if (exp_vld && rsp_rdy) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (acc && !req_wr) begin
                exp_q.push_back(ref_mem[req_addr]);
                due_q.push_back(cyc + 2);
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW-1:0] mask);
        bit got;
        int n;
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; req_wmask = mask;
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = req_rdy;
            if (!got) stalls++;
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: request addr %0d not accepted within %0d cycles", addr, n);
        end
        req_vld = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    logic [AW-1:0] t4_addr [5];
    int            idx;
    int            n;
    bit            accd;

    initial begin
        t4_addr = '{4'd5, 4'd7, 4'd1, 4'd2, 4'd3};
        rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;
        repeat (3) step();

        // zero-fill after reset: 16 init cycles, init_done on the 17th
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 0) chk1("lit_init_dbg_state", dbg_state, 1'b0);
            if (i == DEPTH - 1) begin
                chka("lit_init_last_a", a, 4'd15);
                chk1("lit_init_done_c16", init_done, 1'b0);
            end
        end
        @(negedge clk);
        chk1("lit_init_done_c17", init_done, 1'b1);
        chk1("lit_run_dbg_state", dbg_state, 1'b1);
        step();
        for (int i = 0; i < DEPTH; i++) send(1'b0, AW'(i), '0, '0);
        repeat (4) step();

        // write then read the same address
        send(1'b1, 4'd5, PAT_A5, ALL1);
        send(1'b0, 4'd5, '0, '0);
        @(negedge clk);
        chk1("lit_rd5_vld_c1", rsp_vld, 1'b0);
        @(negedge clk);
        chk1("lit_rd5_vld_c2", rsp_vld, 1'b1);
        chk("lit_rd5_data", rsp_data, PAT_A5);
        step();
        repeat (3) step();

        // bit-masked writes, including an all-zero mask
        send(1'b1, 4'd7, ALL1, ALL1);
        send(1'b1, 4'd7, '0, MASK_LO);
        send(1'b1, 4'd7, {8{16'h1234}}, '0);
        send(1'b0, 4'd7, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk1("lit_rd7_vld", rsp_vld, 1'b1);
        chk("lit_rd7_data", rsp_data, EXP7);
        step();
        repeat (3) step();

        // credit limit with a stalled consumer
        send(1'b1, 4'd1, PAT_11, ALL1);
        send(1'b1, 4'd2, PAT_22, ALL1);
        send(1'b1, 4'd3, PAT_33, ALL1);
        repeat (2) step();
        rsp_rdy = 1'b0;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            req_vld = 1'b1; req_wr = 1'b0; req_addr = t4_addr[idx];
            @(negedge clk);
            accd = req_rdy;
            step();
            if (accd) idx++;
        end
        chki("lit_credit_accepts", idx, 3);
        @(negedge clk);
        chk1("lit_credit_rdy_low", req_rdy, 1'b0);
        chk1("lit_credit_vld_held", rsp_vld, 1'b1);
        chk("lit_credit_head", rsp_data, PAT_A5);
        step();
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("lit_credit_head_pop", rsp_data, PAT_A5);
        step();
        n = 0;
        while (idx < 5 && n < 30) begin
            req_addr = t4_addr[idx];
            @(negedge clk);
            accd = req_rdy;
            step();
            if (accd) idx++;
            n++;
        end
        req_vld = 1'b0;
        chki("lit_credit_all_accepted", idx, 5);
        repeat (6) step();

        // sustained one-read-per-cycle throughput
        stalls = 0;
        for (int i = 0; i < 8; i++) send(1'b0, AW'(i), '0, '0);
        chki("lit_stream_stalls", stalls, 0);
        repeat (6) step();

        // reset in the middle of the zero-fill
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chka("lit_mid_init_a9", a, 4'd9);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk1("lit_mid_rst_cen", cen, 1'b1);
        chka("lit_mid_rst_a", a, 4'd0);
        chk1("lit_mid_rst_init_done", init_done, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 0) chka("lit_restart_a0", a, 4'd0);
            if (i == DEPTH - 1) chk1("lit_restart_done_c16", init_done, 1'b0);
        end
        @(negedge clk);
        chk1("lit_restart_done_c17", init_done, 1'b1);
        step();
        send(1'b0, 4'd5, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk1("lit_refill_vld", rsp_vld, 1'b1);
        chk("lit_refill_data", rsp_data, '0);
        step();
        repeat (4) step();

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ct_f_spsram_req_ctrl.md
Name: ct_f_spsram_req_ctrl

Overview:
- Initiator-side controller for the FPGA single-port SRAM wrapper interface (A/CEN/GWEN/WEN/D/Q: active-low enables, bit-level active-low write mask, synchronous read).
- Converts a valid/ready request stream into SRAM cycles and returns read data on a valid/ready response stream through a credit-protected FIFO.
- Optionally zero-fills the whole array after reset before accepting traffic.
- Sits between a cache/buffer pipeline and one SRAM macro instance.

Parameters:
- ADDR_WIDTH, 14, SRAM address width; array depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 128, SRAM data width.
- RSP_DEPTH, 3, response FIFO entries (min 2).
- INIT_EN, 1, 1 = zero-fill array after reset; 0 = skip.

Ports:
- CLK  input  1  clock, shared with SRAM
- RST  input  1  synchronous active-high reset
- req_vld  input  1  request valid
- req_rdy  output  1  request accepted when req_vld&&req_rdy
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- req_wmask  input  DATA_WIDTH  active-high bit write mask
- rsp_vld  output  1  read data valid
- rsp_rdy  input  1  consumer ready
- rsp_data  output  DATA_WIDTH  read data, in request order
- init_done  output  1  array initialised, traffic allowed
- A  output  ADDR_WIDTH  SRAM address
- CEN  output  1  SRAM chip enable, active low
- GWEN  output  1  SRAM global write enable, active low
- WEN  output  DATA_WIDTH  SRAM bit write enable, active low
- D  output  DATA_WIDTH  SRAM write data
- Q  input  DATA_WIDTH  SRAM read data, valid the cycle after the read edge

Behaviour:
- One clock, CLK; RST is synchronous, active-high.
- Reset values: req_rdy=0, rsp_vld=0, init_done=0, CEN=1, GWEN=1, WEN=all 1, A=0, D=0; FIFO empty, inflight=0, init counter=0.
- FSM states: INIT, RUN. Reset enters INIT if INIT_EN=1, else RUN (init_done=1 the first cycle after RST deasserts).
- INIT: each cycle CEN=0, GWEN=0, WEN=0, D=0, A=init_cnt; init_cnt increments.
  - After the write to address 2^ADDR_WIDTH-1, go to RUN; init_done=1 on the next cycle. Init takes exactly 2^ADDR_WIDTH cycles.
  - req_rdy=0 throughout INIT.
  - RST during INIT restarts at address 0.
- RUN, write: req_rdy=1 unconditionally.
  - On accept, same cycle: CEN=0, GWEN=0, A=req_addr, D=req_wdata, WEN=~req_wmask.
  - A write produces no response.
- RUN, read: req_rdy = (fifo_cnt + inflight) < RSP_DEPTH.
  - The rule is registered-state only; no combinational path from rsp_rdy to req_rdy.
  - On accept, same cycle: CEN=0, GWEN=1, A=req_addr, WEN=all 1.
  - inflight (0/1 register) sets on the next edge.
- Read data: while inflight=1, Q is pushed into the FIFO at the end of that cycle and inflight clears (unless a new read issues).
  - Accept-to-rsp_vld latency is 2 cycles.
  - With rsp_rdy held at 1, one read per cycle is sustained.
- FIFO: rsp_vld = fifo non-empty; rsp_data = head; pop on rsp_vld&&rsp_rdy.
  - Simultaneous push and pop keeps fifo_cnt unchanged.
  - Overflow is impossible by credit; rsp_data is held stable while rsp_vld&&!rsp_rdy.
- Idle (no accept): CEN=1, GWEN=1, WEN=all 1. A and D hold their last driven values.
- Ordering: a write followed by a read to the same address returns the new data. Responses are strictly in order.
- Masked write: req_wmask=0 still issues the SRAM cycle, which modifies nothing.

Test Plan:
- INIT_EN=1, ADDR_WIDTH=4, release RST -> 16 cycles of CEN=0/GWEN=0/D=0, A=0..15; init_done rises cycle 17; reads of all 16 addresses return 0.
- Write addr 5 data 0xA5A5…, mask all 1, then read addr 5 next cycle -> rsp_vld 2 cycles after the read accept, rsp_data=0xA5A5….
- Write addr 7 = 0xFFFF…, then write 0 with mask=0x00FF…FF, read 7 -> 0xFF00…00 (only low 120 bits cleared; top 8 bits stay 1).
- rsp_rdy=0, issue 5 back-to-back reads -> exactly 3 accepted, req_rdy=0 after; raise rsp_rdy -> 3 responses in order, remaining reads then accepted.
- rsp_rdy=1, 8 consecutive reads, addresses 0..7 -> req_rdy never drops, rsp_vld continuous for 8 cycles starting 2 cycles after the first accept.
- Assert RST at init_cnt=9 -> all outputs at reset values next cycle; init restarts at A=0 and completes after a full 2^ADDR_WIDTH cycles.
